// File: rtl/rs_encode_req_arbiter.sv
// Round-robin arbiter that shares one RS encoder among NUM_CLIENTS requesters.
// The grant is held from the request handshake until the response line with last set is accepted.
module rs_encode_req_arbiter #(
    parameter int NUM_CLIENTS      = 4,
    parameter int NUM_REQ_BLOCKS_W = 8,
    parameter int DATA_W           = 512,
    parameter int LINES_PER_BLOCK  = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_CLIENTS-1:0]                  client_req_val,
    input  logic [NUM_CLIENTS*NUM_REQ_BLOCKS_W-1:0] client_req_num_blocks,
    output logic [NUM_CLIENTS-1:0]                  client_req_rdy,
    input  logic [NUM_CLIENTS-1:0]                  client_data_val,
    input  logic [NUM_CLIENTS*DATA_W-1:0]           client_data,
    output logic [NUM_CLIENTS-1:0]                  client_data_rdy,
    output logic [NUM_CLIENTS-1:0]                  client_resp_val,
    output logic [DATA_W-1:0]                       client_resp_data,
    output logic                                    client_resp_last,
    input  logic [NUM_CLIENTS-1:0]                  client_resp_rdy,
    output logic                                    enc_req_val,
    output logic [NUM_REQ_BLOCKS_W-1:0]             enc_req_num_blocks,
    input  logic                                    enc_req_rdy,
    output logic                                    enc_data_val,
    output logic [DATA_W-1:0]                       enc_data,
    input  logic                                    enc_data_rdy,
    input  logic                                    enc_resp_val,
    input  logic [DATA_W-1:0]                       enc_resp_data,
    input  logic                                    enc_resp_last,
    output logic                                    enc_resp_rdy,
    output logic [$clog2(NUM_CLIENTS)-1:0]          grant_id,
    output logic                                    busy,
    output logic                                    err_zero_req
);

    localparam int ID_W  = $clog2(NUM_CLIENTS);
    localparam int NRB_W = NUM_REQ_BLOCKS_W;
    localparam int CNT_W = NRB_W + $clog2(LINES_PER_BLOCK) + 1;

    typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   scan_idx;
    logic              any_req;
    logic [CNT_W-1:0]  lines_total;
    logic [CNT_W-1:0]  line_cnt;
    logic              req_hs;
    logic              data_hs;
    logic              zero_ack;
    logic              resp_last_hs;
    logic [NRB_W-1:0]  g_num_blocks;

    logic [DATA_W-1:0] data_vec [NUM_CLIENTS];
    logic [NRB_W-1:0]  nb_vec   [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign data_vec[i] = client_data[i*DATA_W +: DATA_W];
        assign nb_vec[i]   = client_req_num_blocks[i*NRB_W +: NRB_W];
    end

    assign g_num_blocks = nb_vec[grant_id];
    assign busy         = (state != IDLE);

    // First requester after rr_ptr, wrapping modulo NUM_CLIENTS.
    always_comb begin
        winner   = '0;
        any_req  = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_CLIENTS);
            if (!any_req && client_req_val[scan_idx]) begin
                winner  = scan_idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        client_req_rdy     = '0;
        client_data_rdy    = '0;
        client_resp_val    = '0;
        client_resp_data   = '0;
        client_resp_last   = 1'b0;
        enc_req_val        = 1'b0;
        enc_req_num_blocks = '0;
        enc_data_val       = 1'b0;
        enc_data           = '0;
        enc_resp_rdy       = 1'b0;
        req_hs             = 1'b0;
        data_hs            = 1'b0;
        zero_ack           = 1'b0;
        resp_last_hs       = 1'b0;

        if (state == DATA || state == DRAIN) begin
            client_resp_val[grant_id] = enc_resp_val;
            enc_resp_rdy              = client_resp_rdy[grant_id];
            client_resp_data          = enc_resp_data;
            client_resp_last          = enc_resp_last;
            resp_last_hs = enc_resp_val & client_resp_rdy[grant_id] & enc_resp_last;
        end

        case (state)
            IDLE: begin
                if (any_req) state_nxt = REQ;
            end
            REQ: begin
                // Zero-length requests are acknowledged locally; the encoder never sees them.
                if (g_num_blocks == '0) begin
                    client_req_rdy[grant_id] = client_req_val[grant_id];
                    zero_ack = client_req_val[grant_id];
                    if (zero_ack) state_nxt = IDLE;
                end else begin
                    enc_req_val              = client_req_val[grant_id];
                    enc_req_num_blocks       = g_num_blocks;
                    client_req_rdy[grant_id] = enc_req_rdy;
                    req_hs = client_req_val[grant_id] & enc_req_rdy;
                    if (req_hs) state_nxt = DATA;
                end
            end
            DATA: begin
                enc_data_val              = client_data_val[grant_id];
                enc_data                  = data_vec[grant_id];
                client_data_rdy[grant_id] = enc_data_rdy;
                data_hs = client_data_val[grant_id] & enc_data_rdy;
                if (data_hs && line_cnt == lines_total - CNT_W'(1)) begin
                    state_nxt = resp_last_hs ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (resp_last_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant_id     <= '0;
            rr_ptr       <= ID_W'(NUM_CLIENTS - 1);
            lines_total  <= '0;
            line_cnt     <= '0;
            err_zero_req <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                grant_id <= winner;
                rr_ptr   <= winner;
            end
            if (req_hs) begin
                lines_total <= CNT_W'(g_num_blocks) * CNT_W'(LINES_PER_BLOCK);
                line_cnt    <= '0;
            end else if (data_hs) begin
                line_cnt <= line_cnt + CNT_W'(1);
            end
            if (zero_ack) err_zero_req <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rs_encode_req_arbiter.sv
// Directed bench for rs_encode_req_arbiter; the bench itself plays the encoder and all clients.
module tb_rs_encode_req_arbiter;

    localparam int NC    = 4;
    localparam int NRB_W = 8;
    localparam int DW    = 512;
    localparam int LPB   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NC-1:0]       client_req_val;
    logic [NC*NRB_W-1:0] client_req_num_blocks;
    logic [NC-1:0]       client_req_rdy;
    logic [NC-1:0]       client_data_val;
    logic [NC*DW-1:0]    client_data;
    logic [NC-1:0]       client_data_rdy;
    logic [NC-1:0]       client_resp_val;
    logic [DW-1:0]       client_resp_data;
    logic                client_resp_last;
    logic [NC-1:0]       client_resp_rdy;
    logic                enc_req_val;
    logic [NRB_W-1:0]    enc_req_num_blocks;
    logic                enc_req_rdy;
    logic                enc_data_val;
    logic [DW-1:0]       enc_data;
    logic                enc_data_rdy;
    logic                enc_resp_val;
    logic [DW-1:0]       enc_resp_data;
    logic                enc_resp_last;
    logic                enc_resp_rdy;
    logic [1:0]          grant_id;
    logic                busy;
    logic                err_zero_req;

    int checks = 0;
    int errors = 0;

    rs_encode_req_arbiter #(
        .NUM_CLIENTS(NC), .NUM_REQ_BLOCKS_W(NRB_W), .DATA_W(DW), .LINES_PER_BLOCK(LPB)
    ) dut (
        .clk(clk), .rst(rst),
        .client_req_val(client_req_val), .client_req_num_blocks(client_req_num_blocks),
        .client_req_rdy(client_req_rdy),
        .client_data_val(client_data_val), .client_data(client_data),
        .client_data_rdy(client_data_rdy),
        .client_resp_val(client_resp_val), .client_resp_data(client_resp_data),
        .client_resp_last(client_resp_last), .client_resp_rdy(client_resp_rdy),
        .enc_req_val(enc_req_val), .enc_req_num_blocks(enc_req_num_blocks),
        .enc_req_rdy(enc_req_rdy),
        .enc_data_val(enc_data_val), .enc_data(enc_data), .enc_data_rdy(enc_data_rdy),
        .enc_resp_val(enc_resp_val), .enc_resp_data(enc_resp_data),
        .enc_resp_last(enc_resp_last), .enc_resp_rdy(enc_resp_rdy),
        .grant_id(grant_id), .busy(busy), .err_zero_req(err_zero_req)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        client_req_val        = '0;
        client_req_num_blocks = '0;
        client_data_val       = '0;
        client_data           = '0;
        client_resp_rdy       = '0;
        enc_req_rdy           = 1'b0;
        enc_data_rdy          = 1'b0;
        enc_resp_val          = 1'b0;
        enc_resp_data         = '0;
        enc_resp_last         = 1'b0;
    endtask

    // Advance until the encoder request channel is valid (sampled at negedge+1).
    task automatic wait_enc_req();
        int n = 0;
        while (!enc_req_val && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (!enc_req_val) begin
            checks++; errors++;
            $display("FAIL wait_enc_req: enc_req_val=%0b after %0d cycles, required 1", enc_req_val, n);
        end
    endtask

    // Stream nlines data lines with full throughput, then one response line with last.
    task automatic finish_txn(input int nlines);
        int n = 0;
        int t = 0;
        while (n < nlines && t < 400) begin
            @(negedge clk);
            client_req_val  = '0;
            enc_data_rdy    = 1'b1;
            client_data_val = '1;
            #1;
            if (enc_data_val) n++;
            t++;
        end
        @(negedge clk);
        enc_data_rdy    = 1'b0;
        client_data_val = '0;
        enc_resp_val    = 1'b1;
        enc_resp_last   = 1'b1;
        client_resp_rdy = '1;
        #1;
        t = 0;
        while (!enc_resp_rdy && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        if (n != nlines || !enc_resp_rdy) begin
            checks++; errors++;
            $display("FAIL finish_txn: lines=%0d resp_rdy=%0b, required %0d and 1", n, enc_resp_rdy, nlines);
        end
        @(negedge clk);
        enc_resp_val    = 1'b0;
        enc_resp_last   = 1'b0;
        client_resp_rdy = '0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        client_req_val = '1;
        client_req_num_blocks = {NC{8'd1}};
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || err_zero_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b grant=%0d err=%0b, required 0 0 0", busy, grant_id, err_zero_req);
        end
        checks++;
        if (client_req_rdy !== 4'b0 || enc_req_val !== 1'b0 || client_resp_val !== 4'b0 ||
            client_data_rdy !== 4'b0 || enc_data_val !== 1'b0 || enc_resp_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req_rdy=%b enc_req_val=%b resp_val=%b, required all 0",
                     client_req_rdy, enc_req_val, client_resp_val);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #1;
    endtask

    task automatic test_single();
        @(negedge clk);
        client_req_val = 4'b0001;
        client_req_num_blocks = {NC{8'd2}};
        enc_req_rdy = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || enc_req_val !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%0b enc_req_val=%0b, required 0 0", busy, enc_req_val);
        end
        @(negedge clk); #1;
        checks++;
        if (grant_id !== 2'd0 || busy !== 1'b1 || enc_req_val !== 1'b1 ||
            enc_req_num_blocks !== 8'd2 || client_req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL single_req: grant=%0d busy=%0b val=%0b nb=%0d rdy=%b, required 0 1 1 2 0001",
                     grant_id, busy, enc_req_val, enc_req_num_blocks, client_req_rdy);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            client_req_val  = '0;
            enc_data_rdy    = 1'b1;
            client_data_val = 4'b0001;
            client_data[0 +: DW] = DW'(i + 1);
            #1;
            checks++;
            if (i < 8) begin
                if (enc_data_val !== 1'b1 || enc_data !== DW'(i + 1) || client_data_rdy !== 4'b0001) begin
                    errors++;
                    $display("FAIL single_data[%0d]: val=%0b data=%0d rdy=%b, required 1 %0d 0001",
                             i, enc_data_val, enc_data[31:0], client_data_rdy, i + 1);
                end
            end else if (enc_data_val !== 1'b0 || client_data_rdy !== 4'b0000) begin
                errors++;
                $display("FAIL single_ninth_line: val=%0b rdy=%b, required 0 0000", enc_data_val, client_data_rdy);
            end
        end
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            client_data_val = '0;
            enc_data_rdy    = 1'b0;
            enc_resp_val    = 1'b1;
            enc_resp_data   = DW'(r + 50);
            enc_resp_last   = (r == 1);
            client_resp_rdy = 4'b0001;
            #1;
            checks++;
            if (client_resp_val !== 4'b0001 || client_resp_data !== DW'(r + 50) ||
                client_resp_last !== (r == 1) || enc_resp_rdy !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_resp[%0d]: val=%b data=%0d last=%0b rdy=%0b busy=%0b, required 0001 %0d %0b 1 1",
                         r, client_resp_val, client_resp_data[31:0], client_resp_last, enc_resp_rdy, busy, r + 50, r == 1);
            end
        end
        @(negedge clk);
        enc_resp_val = 1'b0; enc_resp_last = 1'b0; client_resp_rdy = '0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_drop: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int exp;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        client_req_num_blocks = {NC{8'd1}};
        for (int c = 0; c < NC; c++) client_data[c*DW +: DW] = DW'(c + 100);
        client_req_val  = '1;
        client_data_val = '1;
        enc_req_rdy     = 1'b1;
        enc_data_rdy    = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp = k % NC;
            wait_enc_req();
            checks++;
            if (grant_id !== 2'(exp) || client_req_rdy !== 4'(1 << exp) || enc_req_num_blocks !== 8'd1) begin
                errors++;
                $display("FAIL rr_grant[%0d]: grant=%0d rdy=%b nb=%0d, required %0d", k, grant_id, client_req_rdy,
                         enc_req_num_blocks, exp);
            end
            for (int j = 0; j < LPB; j++) begin
                @(negedge clk); #1;
                checks++;
                if (enc_data_val !== 1'b1 || enc_data !== DW'(exp + 100) || client_data_rdy !== 4'(1 << exp)) begin
                    errors++;
                    $display("FAIL rr_data[%0d.%0d]: val=%0b data=%0d rdy=%b, required 1 %0d", k, j, enc_data_val,
                             enc_data[31:0], client_data_rdy, exp + 100);
                end
            end
            @(negedge clk);
            if (k == 4) client_req_val = '0;
            enc_resp_val = 1'b1; enc_resp_last = 1'b1; client_resp_rdy = '1;
            #1;
            checks++;
            if (client_data_rdy !== 4'b0 || enc_data_val !== 1'b0 || client_resp_val !== 4'(1 << exp)) begin
                errors++;
                $display("FAIL rr_drain[%0d]: data_rdy=%b data_val=%0b resp_val=%b, required 0000 0 onehot %0d",
                         k, client_data_rdy, enc_data_val, client_resp_val, exp);
            end
            @(negedge clk);
            enc_resp_val = 1'b0; enc_resp_last = 1'b0; client_resp_rdy = '0;
            #1;
        end
        client_data_val = '0;
        enc_data_rdy    = 1'b0;
    endtask

    task automatic test_zero_req();
        @(negedge clk);
        client_req_num_blocks = {8'd1, 8'd0, 8'd1, 8'd1};
        client_req_val = 4'b1100;
        enc_req_rdy    = 1'b1;
        #1;
        @(negedge clk); #1;
        checks++;
        if (grant_id !== 2'd2 || client_req_rdy !== 4'b0100 || enc_req_val !== 1'b0) begin
            errors++;
            $display("FAIL zero_req_ack: grant=%0d rdy=%b enc_val=%0b, required 2 0100 0", grant_id, client_req_rdy,
                     enc_req_val);
        end
        @(negedge clk); #1;
        checks++;
        if (err_zero_req !== 1'b1 || busy !== 1'b0 || client_req_rdy !== 4'b0 || enc_req_val !== 1'b0) begin
            errors++;
            $display("FAIL zero_req_after: err=%0b busy=%0b rdy=%b enc_val=%0b, required 1 0 0000 0", err_zero_req,
                     busy, client_req_rdy, enc_req_val);
        end
        @(negedge clk); #1;
        checks++;
        if (grant_id !== 2'd3 || enc_req_val !== 1'b1 || enc_req_num_blocks !== 8'd1) begin
            errors++;
            $display("FAIL zero_req_next: grant=%0d enc_val=%0b nb=%0d, required 3 1 1", grant_id, enc_req_val,
                     enc_req_num_blocks);
        end
        finish_txn(LPB);
        checks++;
        if (err_zero_req !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_req_sticky: err=%0b busy=%0b, required 1 0", err_zero_req, busy);
        end
    endtask

    task automatic test_backpressure();
        int nxt = 0;
        int t = 0;
        int r = 0;
        @(negedge clk);
        client_req_num_blocks = {NC{8'd255}};
        client_req_val = 4'b0001;
        enc_req_rdy    = 1'b1;
        #1;
        wait_enc_req();
        checks++;
        if (grant_id !== 2'd0 || enc_req_num_blocks !== 8'd255) begin
            errors++;
            $display("FAIL bp_req: grant=%0d nb=%0d, required 0 255", grant_id, enc_req_num_blocks);
        end
        while (nxt < 255 * LPB && t < 6000) begin
            @(negedge clk);
            client_req_val     = '0;
            enc_data_rdy       = 1'($urandom_range(0, 1));
            client_data_val[0] = 1'($urandom_range(0, 3) != 0);
            client_data[0 +: DW] = DW'(nxt);
            #1;
            if (client_data_val[0] && enc_data_rdy) begin
                checks++;
                if (enc_data_val !== 1'b1 || enc_data !== DW'(nxt) || client_data_rdy !== 4'b0001) begin
                    errors++;
                    $display("FAIL bp_line[%0d]: val=%0b data=%0d rdy=%b, required 1 %0d 0001", nxt, enc_data_val,
                             enc_data[31:0], client_data_rdy, nxt);
                end
                nxt++;
            end
            t++;
        end
        checks++;
        if (nxt != 255 * LPB) begin
            errors++;
            $display("FAIL bp_line_count: delivered=%0d, required %0d", nxt, 255 * LPB);
        end
        @(negedge clk);
        client_data_val = 4'b0001;
        enc_data_rdy    = 1'b1;
        #1;
        checks++;
        if (enc_data_val !== 1'b0 || client_data_rdy !== 4'b0) begin
            errors++;
            $display("FAIL bp_extra_line: val=%0b rdy=%b, required 0 0000", enc_data_val, client_data_rdy);
        end
        t = 0;
        while (r < 4 && t < 200) begin
            @(negedge clk);
            client_data_val = '0;
            enc_data_rdy    = 1'b0;
            enc_resp_val    = 1'b1;
            enc_resp_data   = DW'(r + 1000);
            enc_resp_last   = (r == 3);
            client_resp_rdy = {3'b000, 1'($urandom_range(0, 1))};
            #1;
            checks++;
            if (client_resp_val !== 4'b0001 || client_resp_data !== DW'(r + 1000) ||
                enc_resp_rdy !== client_resp_rdy[0]) begin
                errors++;
                $display("FAIL bp_resp[%0d]: val=%b data=%0d rdy=%0b, required 0001 %0d %0b", r, client_resp_val,
                         client_resp_data[31:0], enc_resp_rdy, r + 1000, client_resp_rdy[0]);
            end
            if (client_resp_rdy[0]) r++;
            t++;
        end
        @(negedge clk);
        enc_resp_val = 1'b0; enc_resp_last = 1'b0; client_resp_rdy = '0;
        #1;
        checks++;
        if (r != 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: resp_lines=%0d busy=%0b, required 4 0", r, busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        client_req_num_blocks = {NC{8'd1}};
        client_req_val = 4'b0100;
        enc_req_rdy    = 1'b1;
        #1;
        wait_enc_req();
        checks++;
        if (grant_id !== 2'd2) begin
            errors++;
            $display("FAIL rstmid_grant: grant=%0d, required 2", grant_id);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            client_req_val  = '0;
            enc_data_rdy    = 1'b1;
            client_data_val = '1;
            #1;
        end
        @(negedge clk);
        client_req_val  = '1;
        enc_resp_val    = 1'b1;
        client_resp_rdy = '1;
        rst = 1'b1;
        #1;
        checks++;
        if (enc_data_val !== 1'b0 || client_data_rdy !== 4'b0 || client_resp_val !== 4'b0 ||
            enc_resp_rdy !== 1'b0 || enc_req_val !== 1'b0 || client_req_rdy !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: dval=%0b drdy=%b rval=%b rrdy=%0b, required all 0", enc_data_val,
                     client_data_rdy, client_resp_val, enc_resp_rdy);
        end
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || err_zero_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: busy=%0b grant=%0d err=%0b, required 0 0 0", busy, grant_id, err_zero_req);
        end
        @(negedge clk);
        rst = 1'b0;
        enc_resp_val = 1'b0; client_resp_rdy = '0; client_data_val = '0; enc_data_rdy = 1'b0;
        #1;
        wait_enc_req();
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_first_grant: grant=%0d, required 0", grant_id);
        end
        finish_txn(LPB);
    endtask

    task automatic test_drain_hold();
        @(negedge clk);
        client_req_num_blocks = {NC{8'd1}};
        client_req_val = 4'b0010;
        enc_req_rdy    = 1'b1;
        #1;
        wait_enc_req();
        checks++;
        if (grant_id !== 2'd1) begin
            errors++;
            $display("FAIL hold_grant1: grant=%0d, required 1", grant_id);
        end
        for (int j = 0; j < LPB; j++) begin
            @(negedge clk);
            client_req_val  = '0;
            enc_data_rdy    = 1'b1;
            client_data_val = '1;
            #1;
        end
        @(negedge clk);
        client_data_val = '0;
        enc_data_rdy    = 1'b0;
        client_req_val  = 4'b1000;
        enc_resp_val    = 1'b1;
        enc_resp_last   = 1'b1;
        client_resp_rdy = 4'b1101;
        #1;
        for (int h = 0; h < 5; h++) begin
            if (h > 0) begin
                @(negedge clk); #1;
            end
            checks++;
            if (busy !== 1'b1 || grant_id !== 2'd1 || client_resp_val !== 4'b0010 ||
                enc_resp_rdy !== 1'b0 || client_req_rdy !== 4'b0 || enc_req_val !== 1'b0) begin
                errors++;
                $display("FAIL hold_drain[%0d]: busy=%0b grant=%0d rval=%b rrdy=%0b ereq=%0b, required 1 1 0010 0 0",
                         h, busy, grant_id, client_resp_val, enc_resp_rdy, enc_req_val);
            end
        end
        @(negedge clk);
        client_resp_rdy = 4'b1111;
        #1;
        checks++;
        if (enc_resp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: enc_resp_rdy=%0b, required 1", enc_resp_rdy);
        end
        @(negedge clk);
        enc_resp_val = 1'b0; enc_resp_last = 1'b0; client_resp_rdy = '0;
        #1;
        wait_enc_req();
        checks++;
        if (grant_id !== 2'd3) begin
            errors++;
            $display("FAIL hold_grant3: grant=%0d, required 3", grant_id);
        end
        finish_txn(LPB);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_req();
        test_backpressure();
        test_reset_mid();
        test_drain_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
